// File: rtl/toy_vpack.sv
// Shared constants and types for the toy vector core operand path.
// Feeder FSM state encoding lives here so issue logic can decode it.
package toy_vpack;

   localparam int V_ELEMENT_NUM = 8;
   localparam int V_REG_WIDTH   = 32;
   localparam int ROW_CNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH,
      DONE
   } feed_state_t;

endpackage

// File: rtl/toy_sa_feeder_if.sv
// Command/operand handshake and array-side bundle of the skew feeder.
// master = upstream issue logic, slave = the feeder itself.
interface toy_sa_feeder_if #(
   parameter int V_ELEMENT_NUM = toy_vpack::V_ELEMENT_NUM,
   parameter int V_REG_WIDTH   = toy_vpack::V_REG_WIDTH,
   parameter int ROW_CNT_W     = toy_vpack::ROW_CNT_W
);

   logic                     cmd_vld;
   logic                     cmd_rdy;
   logic [ROW_CNT_W-1:0]     cmd_rows;
   logic                     in_vld;
   logic                     in_rdy;
   logic [V_REG_WIDTH-1:0]   in_data [V_ELEMENT_NUM];
   logic [V_REG_WIDTH-1:0]   in_y [V_ELEMENT_NUM];
   logic [V_REG_WIDTH-1:0]   sa_dout [V_ELEMENT_NUM];
   logic [V_ELEMENT_NUM-1:0] sa_dout_en;
   logic [V_REG_WIDTH-1:0]   sa_dout_y [V_ELEMENT_NUM];
   logic                     busy;
   logic                     tile_done;

   modport master (
      output cmd_vld, cmd_rows, in_vld, in_data, in_y,
      input  cmd_rdy, in_rdy, sa_dout, sa_dout_en, sa_dout_y,
      input  busy, tile_done
   );

   modport slave (
      input  cmd_vld, cmd_rows, in_vld, in_data, in_y,
      output cmd_rdy, in_rdy, sa_dout, sa_dout_en, sa_dout_y,
      output busy, tile_done
   );

endinterface

// File: rtl/toy_sa_skew_lane.sv
// Fixed-depth delay line for one array row: {en, data, y} shift every cycle.
module toy_sa_skew_lane #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] y_in,
   output logic             en_out,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] y_out
);

   logic [DEPTH-1:0] en_q;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] y_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         en_q[0] <= en_in;
         d_q[0]  <= data_in;
         y_q[0]  <= y_in;
         for (int k = 1; k < DEPTH; k++) begin
            en_q[k] <= en_q[k-1];
            d_q[k]  <= d_q[k-1];
            y_q[k]  <= y_q[k-1];
         end
      end
   end

   assign en_out   = en_q[DEPTH-1];
   assign data_out = d_q[DEPTH-1];
   assign y_out    = y_q[DEPTH-1];

endmodule

// File: rtl/toy_sa_feeder.sv
// Skewing feeder: takes a tile command plus cmd_rows operand vectors and
// drives lane i of each accepted vector to the array i+1 cycles later.
module toy_sa_feeder #(
   parameter int V_ELEMENT_NUM = toy_vpack::V_ELEMENT_NUM,
   parameter int V_REG_WIDTH   = toy_vpack::V_REG_WIDTH,
   parameter int ROW_CNT_W     = toy_vpack::ROW_CNT_W
) (
   input logic            clk,
   input logic            rst_n,
   toy_sa_feeder_if.slave io
);

   import toy_vpack::*;

   localparam int FW = (V_ELEMENT_NUM > 2) ? $clog2(V_ELEMENT_NUM) : 1;
   localparam logic [FW-1:0] FLUSH_LEN = FW'(V_ELEMENT_NUM - 1);

   feed_state_t          state;
   feed_state_t          nxt;
   logic [ROW_CNT_W-1:0] rows;
   logic [FW-1:0]        fcnt;
   logic                 cmd_hs;
   logic                 beat;
   logic                 last_beat;

   logic [V_ELEMENT_NUM-1:0] en_q;
   logic [V_REG_WIDTH-1:0]   dq [V_ELEMENT_NUM];
   logic [V_REG_WIDTH-1:0]   yq [V_ELEMENT_NUM];

   assign cmd_hs    = io.cmd_vld & io.cmd_rdy;
   assign beat      = io.in_vld & io.in_rdy;
   assign last_beat = beat && (rows == ROW_CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:
            if (cmd_hs)
               nxt = (io.cmd_rows != '0) ? STREAM : DONE;
         STREAM:
            if (last_beat)
               nxt = (V_ELEMENT_NUM == 1) ? DONE : FLUSH;
         FLUSH:
            if (fcnt == FW'(1)) nxt = DONE;
         DONE:
            nxt = IDLE;
         default:
            nxt = IDLE;
      endcase
   end

   always_comb begin
      io.cmd_rdy   = 1'b0;
      io.in_rdy    = 1'b0;
      io.tile_done = 1'b0;
      io.busy      = (state != IDLE);
      unique case (state)
         IDLE:    io.cmd_rdy   = 1'b1;
         STREAM:  io.in_rdy    = 1'b1;
         DONE:    io.tile_done = 1'b1;
         default: ;
      endcase
   end

   // fcnt holds the remaining flush cycles, loaded as the last beat lands
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rows <= '0;
         fcnt <= '0;
      end else begin
         if (cmd_hs)    rows <= io.cmd_rows;
         else if (beat) rows <= rows - ROW_CNT_W'(1);
         if (last_beat)            fcnt <= FLUSH_LEN;
         else if (state == FLUSH)  fcnt <= fcnt - FW'(1);
      end
   end

   for (genvar i = 0; i < V_ELEMENT_NUM; i++) begin : g_lane
      toy_sa_skew_lane #(
         .DEPTH (i + 1),
         .WIDTH (V_REG_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_in    (beat),
         .data_in  (beat ? io.in_data[i] : '0),
         .y_in     (beat ? io.in_y[i] : '0),
         .en_out   (en_q[i]),
         .data_out (dq[i]),
         .y_out    (yq[i])
      );
   end

   assign io.sa_dout_en = en_q;
   assign io.sa_dout    = dq;
   assign io.sa_dout_y  = yq;

endmodule
